// File: rtl/eau_addr_byte_serializer_pkg.sv
// Shared external-address-unit package.
// Holds the address/data widths, the serializer state encoding, and the
// byte-order selectors that the data-to-address loader also uses.
package eau_addr_byte_serializer_pkg;

   localparam int EAU_AW = 16;
   localparam int EAU_DW = 8;

   typedef enum logic [1:0] {
      EAU_IDLE   = 2'd0,
      EAU_FIRST  = 2'd1,
      EAU_SECOND = 2'd2
   } eau_state_t;

   localparam bit EAU_LOW_FIRST  = 1'b1;
   localparam bit EAU_HIGH_FIRST = 1'b0;

endpackage

// File: rtl/eau_addr_byte_serializer_reg.sv
// Reset-capable load-enable register primitive.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears q to 0
//   en   - load enable
//   d    - data in
//   q    - registered data out
module eau_addr_byte_serializer_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/eau_addr_byte_serializer.sv
// Address-to-data serializer of the external address unit.
// Captures an AW-bit address and presents it on the DW-bit data bus as two
// beats with a valid/ready handshake. Back-to-back words run at 2 cycles/word.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   a        - address word to serialize
//   ai       - capture request, taken when a_ready is high
//   a_ready  - serializer can accept a this cycle
//   d        - byte being driven
//   d_oe     - data output enable for the external tristate
//              (the natural name "do" is a reserved word)
//   d_valid  - d holds a valid byte
//   d_ready  - consumer accepts the byte
//   d_hi     - current byte is the high byte
//   d_last   - current byte is the last of the word
//   busy     - serializer is not idle
//
// state      | meaning
// EAU_IDLE   | no word held, ready to capture
// EAU_FIRST  | presenting first byte of q
// EAU_SECOND | presenting second (last) byte of q, may capture next word
module eau_addr_byte_serializer
   import eau_addr_byte_serializer_pkg::*;
#(
   parameter int AW        = EAU_AW,
   parameter int DW        = EAU_DW,
   parameter bit LOW_FIRST = EAU_LOW_FIRST
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] a,
   input  logic          ai,
   output logic          a_ready,
   output logic [DW-1:0] d,
   output logic          d_oe,
   output logic          d_valid,
   input  logic          d_ready,
   output logic          d_hi,
   output logic          d_last,
   output logic          busy
);

   if (AW != 2 * DW) begin : g_bad_width
      $error("eau_addr_byte_serializer: AW must equal 2*DW");
   end

   eau_state_t    state_q, state_d;
   logic [AW-1:0] q;
   logic [DW-1:0] byte_lo, byte_hi;
   logic          capture;

   // Both halves share the load enable so a word is always taken whole.
   eau_addr_byte_serializer_reg #(.W(DW)) u_q_lo (
      .clk (clk),
      .rst (rst),
      .en  (capture),
      .d   (a[DW-1:0]),
      .q   (q[DW-1:0])
   );

   eau_addr_byte_serializer_reg #(.W(DW)) u_q_hi (
      .clk (clk),
      .rst (rst),
      .en  (capture),
      .d   (a[AW-1:DW]),
      .q   (q[AW-1:DW])
   );

   assign byte_lo = q[DW-1:0];
   assign byte_hi = q[AW-1:DW];
   assign capture = ai && a_ready;
   assign busy    = (state_q != EAU_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= EAU_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      a_ready = 1'b0;
      d_valid = 1'b0;
      d_oe    = 1'b0;
      d       = '0;
      d_hi    = 1'b0;
      d_last  = 1'b0;
      case (state_q)
         EAU_IDLE: begin
            a_ready = 1'b1;
            if (ai)
               state_d = EAU_FIRST;
         end
         EAU_FIRST: begin
            d_valid = 1'b1;
            d_oe    = 1'b1;
            d       = LOW_FIRST ? byte_lo : byte_hi;
            d_hi    = !LOW_FIRST;
            if (d_ready)
               state_d = EAU_SECOND;
         end
         EAU_SECOND: begin
            d_valid = 1'b1;
            d_oe    = 1'b1;
            d       = LOW_FIRST ? byte_hi : byte_lo;
            d_hi    = LOW_FIRST;
            d_last  = 1'b1;
            // The final beat frees q, so a new word can land on the same edge.
            a_ready = d_ready;
            if (d_ready)
               state_d = ai ? EAU_FIRST : EAU_IDLE;
         end
         default: state_d = EAU_IDLE;
      endcase
   end

endmodule

// File: tb/tb_eau_addr_byte_serializer.sv
module tb_eau_addr_byte_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] a   = '0;
   logic        ai  = 1'b0;
   logic        d_ready = 1'b0;

   // lf = LOW_FIRST=1 instance, hf = LOW_FIRST=0 instance, same stimulus
   logic       lf_a_ready, lf_d_oe, lf_d_valid, lf_d_hi, lf_d_last, lf_busy;
   logic [7:0] lf_d;
   logic       hf_a_ready, hf_d_oe, hf_d_valid, hf_d_hi, hf_d_last, hf_busy;
   logic [7:0] hf_d;

   int n_checks = 0;
   int n_pass   = 0;

   logic [9:0] q_lf[$];
   logic [9:0] q_hf[$];

   always #5 clk = ~clk;

   eau_addr_byte_serializer #(.AW(16), .DW(8), .LOW_FIRST(1'b1)) u_lf (
      .clk(clk), .rst(rst), .a(a), .ai(ai), .a_ready(lf_a_ready),
      .d(lf_d), .d_oe(lf_d_oe), .d_valid(lf_d_valid), .d_ready(d_ready),
      .d_hi(lf_d_hi), .d_last(lf_d_last), .busy(lf_busy)
   );

   eau_addr_byte_serializer #(.AW(16), .DW(8), .LOW_FIRST(1'b0)) u_hf (
      .clk(clk), .rst(rst), .a(a), .ai(ai), .a_ready(hf_a_ready),
      .d(hf_d), .d_oe(hf_d_oe), .d_valid(hf_d_valid), .d_ready(d_ready),
      .d_hi(hf_d_hi), .d_last(hf_d_last), .busy(hf_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expected beat = {d, d_hi, d_last}
   task automatic push_word(input logic [15:0] w);
      q_lf.push_back({w[7:0], 1'b0, 1'b0});
      q_lf.push_back({w[15:8], 1'b1, 1'b1});
      q_hf.push_back({w[15:8], 1'b1, 1'b0});
      q_hf.push_back({w[7:0], 1'b0, 1'b1});
   endtask

   // Monitor: every transferred beat is popped from the scoreboard.
   always @(negedge clk) begin
      if (!rst && lf_d_valid && d_ready) begin
         chk("lf_d_oe", {31'd0, lf_d_oe}, 32'd1);
         if (q_lf.size() == 0)
            chk("lf_unexpected_beat", {22'd0, lf_d, lf_d_hi, lf_d_last}, 32'hFFFF);
         else
            chk("lf_beat", {22'd0, lf_d, lf_d_hi, lf_d_last}, {22'd0, q_lf.pop_front()});
      end
      if (!rst && hf_d_valid && d_ready) begin
         chk("hf_d_oe", {31'd0, hf_d_oe}, 32'd1);
         if (q_hf.size() == 0)
            chk("hf_unexpected_beat", {22'd0, hf_d, hf_d_hi, hf_d_last}, 32'hFFFF);
         else
            chk("hf_beat", {22'd0, hf_d, hf_d_hi, hf_d_last}, {22'd0, q_hf.pop_front()});
      end
   end

   initial begin
      // reset state
      step(); step();
      rst = 1'b0;
      #1;
      chk("rst_a_ready", {31'd0, lf_a_ready}, 32'd1);
      chk("rst_d_valid", {31'd0, lf_d_valid}, 32'd0);
      chk("rst_busy",    {31'd0, lf_busy},    32'd0);
      chk("rst_d",       {24'd0, lf_d},       32'd0);
      chk("rst_d_oe",    {31'd0, lf_d_oe},    32'd0);

      // reset mid-word: abandon asynchronously, no beat ever emitted
      step();
      a = 16'h5566; ai = 1'b1;
      step();
      ai = 1'b0;
      chk("mid_d_valid_pre", {31'd0, lf_d_valid}, 32'd1);
      chk("mid_d_pre",       {24'd0, lf_d},       32'h66);
      #2 rst = 1'b1;
      #1;
      chk("mid_d_valid", {31'd0, lf_d_valid}, 32'd0);
      chk("mid_d_oe",    {31'd0, lf_d_oe},    32'd0);
      chk("mid_busy",    {31'd0, lf_busy},    32'd0);
      chk("mid_d",       {24'd0, lf_d},       32'd0);
      chk("mid_hf_busy", {31'd0, hf_busy},    32'd0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_a_ready", {31'd0, lf_a_ready}, 32'd1);
      chk("post_rst_d_valid", {31'd0, lf_d_valid}, 32'd0);

      // basic word, ready held high
      a = 16'hBEEF; ai = 1'b1; d_ready = 1'b1;
      push_word(16'hBEEF);
      step();
      ai = 1'b0; a = 16'h0000;
      step();
      step();
      chk("basic_idle_valid", {31'd0, lf_d_valid}, 32'd0);
      chk("basic_idle_busy",  {31'd0, lf_busy},    32'd0);
      chk("basic_hf_idle",    {31'd0, hf_busy},    32'd0);

      // backpressure: first byte held stable while d_ready low
      d_ready = 1'b0;
      a = 16'h1234; ai = 1'b1;
      push_word(16'h1234);
      step();
      ai = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_lf_d",     {24'd0, lf_d},       32'h34);
         chk("bp_lf_valid", {31'd0, lf_d_valid}, 32'd1);
         chk("bp_lf_last",  {31'd0, lf_d_last},  32'd0);
         chk("bp_hf_d",     {24'd0, hf_d},       32'h12);
         step();
      end
      d_ready = 1'b1;
      step();
      step();
      chk("bp_idle_valid", {31'd0, lf_d_valid}, 32'd0);

      // back-to-back: second word captured on final-beat cycle
      a = 16'hA55A; ai = 1'b1;
      push_word(16'hA55A);
      push_word(16'hC3C3);
      step();
      ai = 1'b0;
      chk("b2b_busy1", {31'd0, lf_busy}, 32'd1);
      step();
      a = 16'hC3C3; ai = 1'b1;
      #1;
      chk("b2b_a_ready_last", {31'd0, lf_a_ready}, 32'd1);
      chk("b2b_busy2", {31'd0, lf_busy}, 32'd1);
      step();
      ai = 1'b0; a = 16'h0000;
      chk("b2b_busy3",  {31'd0, lf_busy},    32'd1);
      chk("b2b_valid3", {31'd0, lf_d_valid}, 32'd1);
      step();
      chk("b2b_busy4", {31'd0, lf_busy}, 32'd1);
      step();
      chk("b2b_idle", {31'd0, lf_busy}, 32'd0);

      // ignored request while in FIRST
      d_ready = 1'b0;
      a = 16'h7788; ai = 1'b1;
      push_word(16'h7788);
      step();
      a = 16'h0F0F; ai = 1'b1;
      #1;
      chk("ign_a_ready", {31'd0, lf_a_ready}, 32'd0);
      step();
      ai = 1'b0; a = 16'h0000;
      chk("ign_d_held", {24'd0, lf_d}, 32'h88);
      d_ready = 1'b1;
      step();
      step();
      chk("ign_idle", {31'd0, lf_d_valid}, 32'd0);
      d_ready = 1'b0;
      step();

      chk("lf_queue_drained", q_lf.size(), 32'd0);
      chk("hf_queue_drained", q_hf.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/eau_addr_byte_serializer.md
Name: eau_addr_byte_serializer

Overview:
- Address-to-data direction of the external address unit (EAU).
- Captures a 16-bit address word and drives it onto the 8-bit data bus as two sequential bytes, with a valid/ready handshake on the data side.
- Complements the data-to-address loader, which assembles an address from high and low byte strobes.
- Used for address push, for example pushing a return address or emitting a pointer over the byte bus.

Parameters:
- AW, 16, address width; must equal 2*DW.
- DW, 8, data bus width.
- LOW_FIRST, 1, byte order: 1 sends the low byte first, 0 sends the high byte first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- a  in  AW  address word to serialize.
- ai  in  1  address-in strobe; a capture request.
- a_ready  out  1  serializer can accept `a` this cycle.
- d  out  DW  byte being driven.
- do  out  1  data output enable; bus-drive qualifier for the external tristate.
- d_valid  out  1  `d` holds a valid byte.
- d_ready  in  1  consumer accepts the byte.
- d_hi  out  1  current byte is the high byte.
- d_last  out  1  current byte is the final byte of the word.
- busy  out  1  serializer is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - `rst` is asynchronous and active-high. It forces state IDLE and clears the holding register to 0.
  - Reset values: d=0, do=0, d_valid=0, d_hi=0, d_last=0, busy=0, a_ready=1 once `rst` deasserts.
- Capture:
  - Capture occurs when ai && a_ready at a rising clk edge.
  - `a` is latched into the AW-bit holding register `q`, and the FSM enters FIRST.
  - Latency: the first byte is valid on the cycle after capture.
- States:
  - IDLE: d_valid=0, do=0, d=0. a_ready=1.
  - FIRST: d_valid=1, do=1.
    - d = q[7:0] if LOW_FIRST, else q[15:8].
    - d_hi = !LOW_FIRST. d_last=0.
    - When d_ready=1, go to SECOND.
  - SECOND: d_valid=1, do=1.
    - d = the other byte of `q`. d_hi = LOW_FIRST. d_last=1.
    - When d_ready=1, go to IDLE, or go to FIRST if a back-to-back capture occurs.
- Handshake:
  - A beat transfers when d_valid && d_ready.
  - While d_ready=0, `d`, d_hi and d_last are held stable. The FSM never drops d_valid before the transfer.
- Back-to-back:
  - a_ready = (state==IDLE) || (state==SECOND && d_ready).
  - If ai is asserted on the final beat's transfer cycle, the new `a` is captured and the FSM goes directly to FIRST. There is no idle bubble, so throughput is 2 cycles per word.
- ai while busy (a_ready=0): ignored. It is not queued, and `q` is unchanged.
- Changes on `a` after capture have no effect on bytes in flight.
- d_ready while IDLE: ignored.
- Reset mid-word: the word is abandoned immediately (asynchronous). No partial byte is re-sent after reset.
- Outputs are registered or decoded from registered state only. There is no combinational path from `a` or `ai` to `d`. The paths d_ready→a_ready and ai→a_ready are as specified above.
- `busy` = (state != IDLE).

Decomposition:
- Shared eau package holds:
  - Constants: EAU_AW=16 and EAU_DW=8.
  - A 2-bit state encoding: EAU_IDLE=0, EAU_FIRST=1, EAU_SECOND=2.
  - Byte-order localparams shared with the data-to-address loader.
- The holding register reuses the existing reset-capable register primitive, instanced as two DW-wide halves so the load enable is shared.
- No other sub-module: the FSM and output mux stay inline.

Test Plan:
- Reset with rst=1 while FIRST is active (d_valid=1) → d_valid, do, busy and `d` go to 0 within the same cycle, without waiting for clk. After release, a_ready=1.
- Basic, LOW_FIRST=1: a=16'hBEEF, ai for 1 cycle, d_ready=1 held.
  - Next cycle: d=8'hEF, d_hi=0, d_last=0.
  - Then: d=8'hBE, d_hi=1, d_last=1.
  - Then: d_valid=0, busy=0.
- Backpressure: a=16'h1234, d_ready=0 for 3 cycles → d=8'h34 stable with d_valid=1 for all 3 cycles. Raising d_ready gives 8'h12 next, then IDLE.
- Back-to-back: 16'hA55A, then ai with a=16'hC3C3 asserted on the last-beat cycle.
  - Byte stream: 5A, A5, C3, C3 on 4 consecutive cycles.
  - d_last=1 on beats 2 and 4.
  - busy stays 1 throughout.
- Ignored request: ai with a=16'h0F0F while in FIRST → stream remains the original word's bytes, and `q` is unchanged.
- LOW_FIRST=0: a=16'hBEEF → BE (d_hi=1) then EF (d_hi=0, d_last=1).
